utrap_seq: RTL and testbench

Microtrap sequencer in the COMET microsequencer: the consumer of the encoded microtrap and micro-vector signals from the access-check logic. It latches a pending microtrap code and aborts the trapping microword. It saves that microword's address on a two-entry trap return stack, forces the next micro-address to the trap vector, and later restores the saved address on a trap-return microorder. It also applies the micro-vector and the force-MA09 modifiers to the next micro-address.

---
 rtl/utrap_seq_pkg.sv | 27 ++
 rtl/utrap_seq_if.sv | 32 +++
 rtl/utrap_seq_rstack.sv | 36 +++
 rtl/utrap_seq.sv | 105 ++++++++++
 tb/tb_utrap_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/utrap_seq_pkg.sv
// Shared types for the microtrap sequencer: FSM state encoding, trap codes, vector helper.
// Purely declarative; no timing or flow-control behaviour of its own.
package utrap_seq_pkg;

  typedef logic [13:0] upc_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ABORT   = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  localparam logic [2:0] UTRAP_NONE = 3'd0;
  localparam logic [2:0] UNAL       = 3'd1;
  localparam logic [2:0] WR_XPG     = 3'd2;
  localparam logic [2:0] WUL_XPG    = 3'd3;
  localparam logic [2:0] UB_UNAL    = 3'd4;
  localparam logic [2:0] WU_UNAL    = 3'd5;
  localparam logic [2:0] FPRES      = 3'd6;
  localparam logic [2:0] PARITY     = 3'd7;

  // Vectors are spaced four microwords apart; the sum wraps at 14 bits.
  function automatic upc_t trap_vector(input upc_t base, input logic [2:0] code);
    return base + {9'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/utrap_seq_if.sv
// Microsequencer-side bus into/out of the trap sequencer; master drives the
// microword context, slave (the sequencer) returns the selected next address.
interface utrap_seq_if;
  import utrap_seq_pkg::*;

  logic        m_clk_en_h;
  logic [2:0]  enc_utrap_l;
  logic [1:0]  micro_vector_h;
  logic        force_ma_09_h;
  logic        uvec_sel_h;
  logic        utrap_ret_h;
  upc_t        upc_cur_h;
  upc_t        upc_next_h;
  upc_t        upc_h;
  logic        abort_h;
  logic        trap_active_h;
  logic [2:0]  trap_code_h;
  logic        double_fault_h;

  modport master (
    output m_clk_en_h, enc_utrap_l, micro_vector_h, force_ma_09_h,
           uvec_sel_h, utrap_ret_h, upc_cur_h, upc_next_h,
    input  upc_h, abort_h, trap_active_h, trap_code_h, double_fault_h
  );

  modport slave (
    input  m_clk_en_h, enc_utrap_l, micro_vector_h, force_ma_09_h,
           uvec_sel_h, utrap_ret_h, upc_cur_h, upc_next_h,
    output upc_h, abort_h, trap_active_h, trap_code_h, double_fault_h
  );

endinterface

// File: rtl/utrap_seq_rstack.sv
// Two-entry trap return stack; top is combinational, push/pop land on the clock edge.
// Push when full and pop when empty are dropped; the caller guards both.
module utrap_rstack
  import utrap_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  upc_t       push_dat,
  output upc_t       top,
  output logic [1:0] depth,
  output logic       full
);

  upc_t entry0;
  upc_t entry1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      depth  <= 2'd0;
    end else if (push && !full) begin
      if (depth == 2'd0) entry0 <= push_dat;
      else               entry1 <= push_dat;
      depth <= depth + 2'd1;
    end else if (pop && depth != 2'd0) begin
      depth <= depth - 2'd1;
    end
  end

  assign full = (depth == 2'd2);
  assign top  = full ? entry1 : entry0;

endmodule

// File: rtl/utrap_seq.sv
// Microtrap sequencer: latches trap codes, aborts the trapping word for one microcycle and
// vectors, restores on trap return; everything stalls while m_clk_en_h is low.
module utrap_seq
  import utrap_seq_pkg::*;
#(
  parameter upc_t UTRAP_BASE = 14'h0040,
  parameter upc_t DFAULT_VEC = 14'h0060
) (
  input  logic         b_clk_l,
  input  logic         init_l,
  utrap_seq_if.slave   bus
);

  logic       b_clk_h;
  logic [2:0] code;
  logic       parity_hit;
  logic       trap_take;
  logic       ret_take;

  state_e     state;
  logic [2:0] trap_code_q;
  logic       dfault_q;
  logic       dfault_now_q;

  upc_t       stk_top;
  logic [1:0] stk_depth;
  logic       stk_full;
  upc_t       upc_sel;

  assign b_clk_h    = ~b_clk_l;
  assign code       = ~bus.enc_utrap_l;
  assign parity_hit = (code == PARITY);

  // Inside a handler only a control-store parity error may interrupt; it also beats a return.
  assign trap_take = bus.m_clk_en_h &&
                     (((state == ST_IDLE) && (code != UTRAP_NONE)) ||
                      ((state == ST_SERVICE) && parity_hit));
  assign ret_take  = bus.m_clk_en_h && (state == ST_SERVICE) &&
                     bus.utrap_ret_h && !parity_hit;

  utrap_rstack u_rstack (
    .clk      (b_clk_h),
    .rst_n    (init_l),
    .push     (trap_take && !stk_full),
    .pop      (ret_take),
    .push_dat (bus.upc_cur_h),
    .top      (stk_top),
    .depth    (stk_depth),
    .full     (stk_full)
  );

  always_ff @(posedge b_clk_h or negedge init_l) begin
    if (!init_l) begin
      state        <= ST_IDLE;
      trap_code_q  <= UTRAP_NONE;
      dfault_q     <= 1'b0;
      dfault_now_q <= 1'b0;
    end else if (bus.m_clk_en_h) begin
      case (state)
        ST_IDLE: begin
          if (code != UTRAP_NONE) begin
            trap_code_q <= code;
            state       <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          dfault_now_q <= 1'b0;
          state        <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (parity_hit) begin
            trap_code_q <= code;
            state       <= ST_ABORT;
            if (stk_full) begin
              dfault_q     <= 1'b1;
              dfault_now_q <= 1'b1;
            end
          end else if (bus.utrap_ret_h && stk_depth == 2'd1) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The vector derives only from registered state, so it holds steady across the abort cycle.
  always_comb begin
    upc_sel = bus.upc_next_h;
    if (state == ST_ABORT) begin
      upc_sel = dfault_now_q ? DFAULT_VEC : trap_vector(UTRAP_BASE, trap_code_q);
    end else begin
      if (ret_take)          upc_sel = stk_top;
      if (bus.uvec_sel_h)    upc_sel[1:0] = upc_sel[1:0] & bus.micro_vector_h;
      if (bus.force_ma_09_h) upc_sel[9] = 1'b1;
    end
  end

  assign bus.upc_h          = upc_sel;
  assign bus.abort_h        = (state == ST_ABORT);
  assign bus.trap_active_h  = (state != ST_IDLE);
  assign bus.trap_code_h    = trap_code_q;
  assign bus.double_fault_h = dfault_q;

endmodule

// File: tb/tb_utrap_seq.sv
// Directed and randomized bench for utrap_seq against a queue-based trap/return model.
module tb_utrap_seq;

  logic b_clk_l;
  logic init_l;

  utrap_seq_if bus ();

  utrap_seq #(
    .UTRAP_BASE (14'h0040),
    .DFAULT_VEC (14'h0060)
  ) dut (
    .b_clk_l (b_clk_l),
    .init_l  (init_l),
    .bus     (bus)
  );

  initial b_clk_l = 1'b1;
  always #5 b_clk_l = ~b_clk_l;

  int checks = 0;
  int passed = 0;

  // Reference model: handler nesting as a queue of saved addresses.
  int stk[$];
  bit m_abort;
  bit m_active;
  bit m_dfjust;
  bit m_df;
  int m_code;

  logic [13:0] obs_upc;
  logic        obs_abort;
  logic        obs_active;
  logic [2:0]  obs_code;
  logic        obs_df;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    stk.delete();
    m_abort  = 0;
    m_active = 0;
    m_dfjust = 0;
    m_df     = 0;
    m_code   = 0;
  endtask

  function automatic int cur_code();
    return 7 - int'(bus.enc_utrap_l);
  endfunction

  function automatic logic [13:0] exp_upc();
    int a;
    int c;
    c = cur_code();
    if (m_abort) return m_dfjust ? 14'h0060 : 14'((64 + 4 * m_code) % 16384);
    if (m_active && bus.utrap_ret_h && bus.m_clk_en_h && c != 7) a = stk[$];
    else a = int'(bus.upc_next_h);
    if (bus.uvec_sel_h) a = a - (a % 4) + ((a % 4) & int'(bus.micro_vector_h));
    if (bus.force_ma_09_h) a = a | 512;
    return 14'(a);
  endfunction

  task automatic model_edge();
    int c;
    c = cur_code();
    if (!bus.m_clk_en_h) return;
    if (m_abort) begin
      m_abort  = 0;
      m_dfjust = 0;
    end else if (!m_active) begin
      if (c != 0) begin
        stk.push_back(int'(bus.upc_cur_h));
        m_code   = c;
        m_abort  = 1;
        m_active = 1;
      end
    end else if (c == 7) begin
      if (stk.size() == 2) begin
        m_df     = 1;
        m_dfjust = 1;
      end else begin
        stk.push_back(int'(bus.upc_cur_h));
      end
      m_code  = 7;
      m_abort = 1;
    end else if (bus.utrap_ret_h) begin
      void'(stk.pop_back());
      if (stk.size() == 0) m_active = 0;
    end
  endtask

  task automatic check_all();
    obs_upc    = bus.upc_h;
    obs_abort  = bus.abort_h;
    obs_active = bus.trap_active_h;
    obs_code   = bus.trap_code_h;
    obs_df     = bus.double_fault_h;
    check("upc",    16'(obs_upc),    16'(exp_upc()));
    check("abort",  16'(obs_abort),  16'(m_abort));
    check("active", 16'(obs_active), 16'(m_active));
    check("code",   16'(obs_code),   16'(m_code));
    check("dfault", 16'(obs_df),     16'(m_df));
  endtask

  task automatic drive(input logic [2:0] enc, input logic [13:0] cur, input logic [13:0] nxt,
                       input logic ret, input logic uvs, input logic fm9,
                       input logic [1:0] mv, input logic en);
    bus.enc_utrap_l    = enc;
    bus.upc_cur_h      = cur;
    bus.upc_next_h     = nxt;
    bus.utrap_ret_h    = ret;
    bus.uvec_sel_h     = uvs;
    bus.force_ma_09_h  = fm9;
    bus.micro_vector_h = mv;
    bus.m_clk_en_h     = en;
  endtask

  // One microcycle: drive, check mid-cycle, take the falling b_clk_l edge, advance the model.
  task automatic cycle(input logic [2:0] enc, input logic [13:0] cur, input logic [13:0] nxt,
                       input logic ret, input logic uvs, input logic fm9,
                       input logic [1:0] mv, input logic en);
    drive(enc, cur, nxt, ret, uvs, fm9, mv, en);
    @(posedge b_clk_l);
    check_all();
    @(negedge b_clk_l);
    model_edge();
    #1;
  endtask

  initial begin
    init_l = 1'b0;
    drive(3'b111, 14'h0000, 14'h0123, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
    model_reset();
    #2;
    check_all();
    check("rst_upc", 16'(bus.upc_h), 16'h0123);
    @(negedge b_clk_l);
    #1 init_l = 1'b1;

    // Idle pass-through.
    cycle(3'b111, 14'h0000, 14'h0123, 0, 0, 0, 2'b11, 1);
    check("idle_upc", 16'(obs_upc), 16'h0123);
    check("idle_active", 16'(obs_active), 16'h0);

    // Code 2 from IDLE, then return.
    cycle(3'b101, 14'h0200, 14'h0124, 0, 0, 0, 2'b11, 1);
    cycle(3'b111, 14'h0201, 14'h0125, 0, 0, 0, 2'b11, 1);
    check("t2_abort", 16'(obs_abort), 16'h1);
    check("t2_vec", 16'(obs_upc), 16'h0048);
    check("t2_code", 16'(obs_code), 16'h2);
    cycle(3'b111, 14'h0048, 14'h0049, 0, 0, 0, 2'b11, 1);
    cycle(3'b111, 14'h0049, 14'h004A, 1, 0, 0, 2'b11, 1);
    check("t2_ret", 16'(obs_upc), 16'h0200);
    cycle(3'b111, 14'h0200, 14'h0201, 0, 0, 0, 2'b11, 1);
    check("t2_idle", 16'(obs_active), 16'h0);

    // Nested parity trap, stall during ABORT, then double fault.
    cycle(3'b101, 14'h0300, 14'h0301, 0, 0, 0, 2'b11, 1);
    cycle(3'b111, 14'h0000, 14'h0001, 0, 0, 0, 2'b11, 0);
    check("hold_abort", 16'(obs_abort), 16'h1);
    cycle(3'b111, 14'h0000, 14'h0001, 0, 0, 0, 2'b11, 1);
    check("hold_vec", 16'(obs_upc), 16'h0048);
    cycle(3'b010, 14'h0049, 14'h004A, 0, 0, 0, 2'b11, 1);
    cycle(3'b000, 14'h0050, 14'h0051, 1, 0, 0, 2'b11, 1);
    check("c5_masked", 16'(obs_abort), 16'h0);
    check("p7_ret_lost", 16'(obs_upc), 16'h0051);
    cycle(3'b111, 14'h005C, 14'h005D, 0, 0, 0, 2'b11, 1);
    check("p7_vec", 16'(obs_upc), 16'h005C);
    cycle(3'b000, 14'h005D, 14'h005E, 0, 0, 0, 2'b11, 1);
    cycle(3'b111, 14'h0060, 14'h0061, 0, 0, 0, 2'b11, 1);
    check("df_flag", 16'(obs_df), 16'h1);
    check("df_vec", 16'(obs_upc), 16'h0060);
    cycle(3'b111, 14'h0061, 14'h0062, 1, 0, 0, 2'b11, 1);
    check("ret_inner", 16'(obs_upc), 16'h0050);
    cycle(3'b111, 14'h0051, 14'h0052, 1, 0, 0, 2'b11, 1);
    check("ret_outer", 16'(obs_upc), 16'h0300);
    cycle(3'b111, 14'h0300, 14'h0301, 0, 0, 0, 2'b11, 1);
    check("back_idle", 16'(obs_active), 16'h0);
    check("df_sticky", 16'(obs_df), 16'h1);

    // Post-modifiers in IDLE.
    cycle(3'b111, 14'h0000, 14'h0103, 0, 1, 1, 2'b01, 1);
    check("modifiers", 16'(obs_upc), 16'h0301);

    // Asynchronous reset in the middle of ABORT.
    cycle(3'b110, 14'h0400, 14'h0401, 0, 0, 0, 2'b11, 1);
    drive(3'b111, 14'h0000, 14'h0777, 0, 0, 0, 2'b11, 1);
    #2 init_l = 1'b0;
    #1;
    model_reset();
    check("rst_abort", 16'(bus.abort_h), 16'h0);
    check("rst_active", 16'(bus.trap_active_h), 16'h0);
    check("rst_upc_mid", 16'(bus.upc_h), 16'h0777);
    check("rst_df", 16'(bus.double_fault_h), 16'h0);
    check_all();
    @(negedge b_clk_l);
    #1 init_l = 1'b1;

    // A single trap/return after reset must return straight to IDLE (depth cleared).
    cycle(3'b110, 14'h0111, 14'h0112, 0, 0, 0, 2'b11, 1);
    cycle(3'b111, 14'h0000, 14'h0001, 0, 0, 0, 2'b11, 1);
    check("post_rst_vec", 16'(obs_upc), 16'h0044);
    cycle(3'b111, 14'h0045, 14'h0046, 1, 0, 0, 2'b11, 1);
    check("post_rst_ret", 16'(obs_upc), 16'h0111);
    cycle(3'b111, 14'h0111, 14'h0112, 0, 0, 0, 2'b11, 1);
    check("post_rst_idle", 16'(obs_active), 16'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] enc;
      enc = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      cycle(enc, 14'($urandom), 14'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), 2'($urandom),
            ($urandom_range(0, 7) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
